ascon128_aead_stream: RTL and testbench
=======================================

Name: ascon128_aead_stream

Overview:
- Streaming Ascon-128 AEAD core. Processes any number of 64-bit associated-data (AD) and message blocks under valid/ready handshakes.
- Supports encrypt and decrypt modes. In decrypt mode it also checks the tag.
- The permutation round count per clock is set by a parameter, so one RTL trades area against throughput.
- It is the generalised successor of the fixed one-AD/one-block encryptor and sits between the host DMA/stream fabric and the tag/key management logic.

Parameters:
UNROLL, 6, Ascon rounds evaluated per clock; legal values 1, 2, 3, 6 (must divide 6 and 12); any other value is an elaboration error.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin operation; sampled only in IDLE
decrypt  in  1  mode, latched at start: 0 = encrypt, 1 = decrypt
ad_en  in  1  latched at start: 1 = AD phase present, 0 = skip AD
key  in  128  K, latched at start
nonce  in  128  N, latched at start
tag_in  in  128  expected tag for decrypt, latched at start
in_valid  in  1  input block valid
in_ready  out  1  core accepts a block on in_valid & in_ready
in_data  in  64  AD, plaintext or ciphertext block; host pre-pads
in_last  in  1  block is last of the current phase (AD or message)
out_valid  out  1  out_data holds a ciphertext/plaintext block
out_ready  in  1  downstream accepts out_data
out_data  out  64  result block
tag  out  128  final tag
tag_valid  out  1  tag (and tag_ok) valid
tag_ok  out  1  decrypt only: tag == tag_in; 0 in encrypt mode
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; state words x0..x4 = 0; in_ready, out_valid, tag_valid, tag_ok, busy = 0; out_data and tag = 0. Reset mid-operation aborts immediately and needs no drain.

Permutation:
- p12 uses round constants f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b. The constant is XORed into x2 before the S-box.
- p6 uses the last six constants.
- Each clock applies UNROLL rounds. A round counter (0..11) selects the constants.
- p12 takes 12/UNROLL cycles; p6 takes 6/UNROLL cycles.

State machine (IDLE, INIT, AD_WAIT, AD_PERM, MSG_WAIT, MSG_PERM, FINAL, DONE):
- IDLE: on start, load {x0..x4} = {64'h80400c0600000000, K, N}, latch decrypt/ad_en/key/tag_in, go to INIT. start outside IDLE is ignored.
- INIT: runs p12. On its last cycle XOR K into {x3,x4}.
  - ad_en = 1: go to AD_WAIT.
  - ad_en = 0: additionally XOR 1 into x4 LSB and go to MSG_WAIT.
- AD_WAIT: in_ready = 1. On accept, x0 ^= in_data, go to AD_PERM.
- AD_PERM: runs p6. On its last cycle, if the accepted block had in_last, XOR 1 into x4 LSB and go to MSG_WAIT; else go to AD_WAIT.
- MSG_WAIT: in_ready = !out_valid | out_ready. On accept:
  - Encrypt: out_data <= x0 ^ in_data; x0 <= x0 ^ in_data.
  - Decrypt: out_data <= x0 ^ in_data; x0 <= in_data.
  - out_valid rises the next cycle.
  - If in_last: x1 ^= K[127:64], x2 ^= K[63:0], go to FINAL. Else go to MSG_PERM.
- MSG_PERM: runs p6, then returns to MSG_WAIT.
- FINAL: runs p12. On its last cycle, tag <= {x3,x4} ^ K and tag_ok <= decrypt & (that value == tag_in). Go to DONE.
- DONE: tag_valid = 1 for exactly one cycle, then IDLE. tag and tag_ok hold until the next start; tag_valid clears at start.

Handshake:
- out_valid is held until out_ready.
- Permutation progress never depends on out_ready; only the next MSG_WAIT accept stalls on it.
- The last out_data may still be pending after tag_valid; it stays valid until taken.
- in_ready = 0 in every state other than AD_WAIT and MSG_WAIT.
- A simultaneous out_ready and new accept in MSG_WAIT is legal: the output register is replaced with no bubble.

Latency:
- INIT = 12/UNROLL cycles.
- Each block = 1 accept cycle + 6/UNROLL cycles.
- FINAL = 12/UNROLL cycles, then 1 cycle in DONE.

Test Plan:
- UNROLL=6, ad_en=1, one AD block (in_last), one message block (in_last), K = N = 0, in blocks 0, out_ready=1 -> ciphertext and tag match the golden model; in_ready rises 2 cycles after start; tag_valid 3 cycles after the message accept; busy falls the cycle after tag_valid.
- Same vectors with UNROLL = 1, 2, 3 -> identical out_data and tag; INIT takes 12, 6 and 4 cycles respectively.
- ad_en=0, 3 message blocks 0x0123456789abcdef, 0x1111111111111111, 0x8000000000000000 -> matches the golden model; no AD_WAIT state is visited.
- Decrypt the ciphertext from the previous case with tag_in = its tag -> plaintext reproduced, tag_ok=1. Flip tag_in bit 0 -> tag_ok=0, tag unchanged.
- out_ready held low 10 cycles after the first output -> in_ready=0 in MSG_WAIT, out_data stable; on release, no block lost or duplicated.
- reset asserted during MSG_PERM -> next cycle busy=0, out_valid=0, in_ready=0, tag_valid=0; start ignored while busy; a fresh run after reset gives the correct tag.

Source files
------------

// File: rtl/ascon128_aead_stream.sv
// Streaming Ascon-128 AEAD core: any number of 64-bit AD/message blocks,
// encrypt or decrypt with tag check, UNROLL permutation rounds per clock.
module ascon128_aead_stream #(
  parameter int unsigned UNROLL = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         decrypt,
  input  logic         ad_en,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [127:0] tag_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         tag_ok,
  output logic         busy
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned RND_W  = 4;
  localparam logic [WORD_W-1:0] IV       = 64'h80400c0600000000;
  localparam logic [RND_W-1:0]  RND_LAST = RND_W'(12 - UNROLL);
  localparam logic [RND_W-1:0]  RND_P6   = RND_W'(6);
  localparam logic [RND_W-1:0]  RND_P12  = RND_W'(0);

  // Reject round counts that do not divide both 6 and 12.
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
    $error("ascon128_aead_stream: UNROLL must be 1, 2, 3 or 6");
  end

  typedef enum logic [2:0] {
    IDLE, INIT, AD_WAIT, AD_PERM, MSG_WAIT, MSG_PERM, FINAL, DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [4:0][WORD_W-1:0]   x_q, x_d, perm_c;
  logic [RND_W-1:0]         rnd_q, rnd_d;
  logic                     dec_q, dec_d;
  logic                     ad_en_q, ad_en_d;
  logic                     ad_last_q, ad_last_d;
  logic [KEY_W-1:0]         key_q, key_d;
  logic [KEY_W-1:0]         tag_in_q, tag_in_d;
  logic [WORD_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [KEY_W-1:0]         tag_q, tag_d;
  logic                     tag_ok_q, tag_ok_d;
  logic                     tag_valid_q, busy_q;
  logic                     in_ready_c, rnd_last_c;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  // One Ascon round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [4:0][WORD_W-1:0] ascon_round(input logic [4:0][WORD_W-1:0] s,
                                                         input logic [RND_W-1:0] r);
    logic [WORD_W-1:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    logic [4:0][WORD_W-1:0] o;
    a0 = s[0];
    a1 = s[1];
    a2 = s[2] ^ {56'd0, 4'(4'd15 - r), r};
    a3 = s[3];
    a4 = s[4];
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    o[0] = a0 ^ rotr(a0, 19) ^ rotr(a0, 28);
    o[1] = a1 ^ rotr(a1, 61) ^ rotr(a1, 39);
    o[2] = a2 ^ rotr(a2, 1)  ^ rotr(a2, 6);
    o[3] = a3 ^ rotr(a3, 10) ^ rotr(a3, 17);
    o[4] = a4 ^ rotr(a4, 7)  ^ rotr(a4, 41);
    return o;
  endfunction

  // UNROLL consecutive rounds starting at the current round counter.
  always_comb begin
    perm_c = x_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      perm_c = ascon_round(perm_c, RND_W'(rnd_q + i));
    end
  end

  assign rnd_last_c = (rnd_q == RND_LAST);

  // Next-state, datapath updates and handshake decode.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    rnd_d       = rnd_q;
    dec_d       = dec_q;
    ad_en_d     = ad_en_q;
    ad_last_d   = ad_last_q;
    key_d       = key_q;
    tag_in_d    = tag_in_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    tag_d       = tag_q;
    tag_ok_d    = tag_ok_q;
    in_ready_c  = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d[0]   = IV;
          x_d[1]   = key[127:64];
          x_d[2]   = key[63:0];
          x_d[3]   = nonce[127:64];
          x_d[4]   = nonce[63:0];
          dec_d    = decrypt;
          ad_en_d  = ad_en;
          key_d    = key;
          tag_in_d = tag_in;
          tag_d    = '0;
          tag_ok_d = 1'b0;
          rnd_d    = RND_P12;
          state_d  = INIT;
        end
      end
      INIT: begin
        x_d   = perm_c;
        rnd_d = RND_W'(rnd_q + UNROLL);
        if (rnd_last_c) begin
          x_d[3] = perm_c[3] ^ key_q[127:64];
          x_d[4] = perm_c[4] ^ key_q[63:0];
          if (ad_en_q) begin
            state_d = AD_WAIT;
          end else begin
            x_d[4][0] = ~x_d[4][0];
            state_d   = MSG_WAIT;
          end
        end
      end
      AD_WAIT: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          x_d[0]    = x_q[0] ^ in_data;
          ad_last_d = in_last;
          rnd_d     = RND_P6;
          state_d   = AD_PERM;
        end
      end
      AD_PERM: begin
        x_d   = perm_c;
        rnd_d = RND_W'(rnd_q + UNROLL);
        if (rnd_last_c) begin
          if (ad_last_q) begin
            x_d[4][0] = ~perm_c[4][0];
            state_d   = MSG_WAIT;
          end else begin
            state_d = AD_WAIT;
          end
        end
      end
      MSG_WAIT: begin
        in_ready_c = !out_valid_q || out_ready;
        if (in_ready_c && in_valid) begin
          out_data_d  = x_q[0] ^ in_data;
          out_valid_d = 1'b1;
          x_d[0]      = dec_q ? in_data : (x_q[0] ^ in_data);
          if (in_last) begin
            x_d[1]  = x_q[1] ^ key_q[127:64];
            x_d[2]  = x_q[2] ^ key_q[63:0];
            rnd_d   = RND_P12;
            state_d = FINAL;
          end else begin
            rnd_d   = RND_P6;
            state_d = MSG_PERM;
          end
        end
      end
      MSG_PERM: begin
        x_d   = perm_c;
        rnd_d = RND_W'(rnd_q + UNROLL);
        if (rnd_last_c) begin
          state_d = MSG_WAIT;
        end
      end
      FINAL: begin
        x_d   = perm_c;
        rnd_d = RND_W'(rnd_q + UNROLL);
        if (rnd_last_c) begin
          tag_d    = {perm_c[3], perm_c[4]} ^ key_q;
          tag_ok_d = dec_q && (tag_d == tag_in_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      rnd_q       <= '0;
      dec_q       <= 1'b0;
      ad_en_q     <= 1'b0;
      ad_last_q   <= 1'b0;
      key_q       <= '0;
      tag_in_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      tag_q       <= '0;
      tag_ok_q    <= 1'b0;
      tag_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      rnd_q       <= rnd_d;
      dec_q       <= dec_d;
      ad_en_q     <= ad_en_d;
      ad_last_q   <= ad_last_d;
      key_q       <= key_d;
      tag_in_q    <= tag_in_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      tag_q       <= tag_d;
      tag_ok_q    <= tag_ok_d;
      tag_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign tag       = tag_q;
  assign tag_ok    = tag_ok_q;
  assign tag_valid = tag_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ascon128_aead_stream.sv
// Bench for ascon128_aead_stream: four instances (UNROLL 6,1,2,3) exercised in
// turn against a table-driven Ascon reference model.
module tb_ascon128_aead_stream;

  localparam int NI = 4;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NI-1:0]    start_a, in_valid_a, out_ready_a;
  logic             decrypt, ad_en, in_last;
  logic [127:0]     key, nonce, tag_in;
  logic [63:0]      in_data;
  logic [NI-1:0]    in_ready_a, out_valid_a, tag_valid_a, tag_ok_a, busy_a;
  logic [63:0]      out_data_a [NI];
  logic [127:0]     tag_a [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned U = (g == 0) ? 6 : (g == 1) ? 1 : (g == 2) ? 2 : 3;
    ascon128_aead_stream #(.UNROLL(U)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_a[g]),
      .decrypt  (decrypt),
      .ad_en    (ad_en),
      .key      (key),
      .nonce    (nonce),
      .tag_in   (tag_in),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_a[g]),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid_a[g]),
      .out_ready(out_ready_a[g]),
      .out_data (out_data_a[g]),
      .tag      (tag_a[g]),
      .tag_valid(tag_valid_a[g]),
      .tag_ok   (tag_ok_a[g]),
      .busy     (busy_a[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int unr_of(input int k);
    return (k == 0) ? 6 : (k == 1) ? 1 : (k == 2) ? 2 : 3;
  endfunction

  // ---------------- reference model ----------------
  logic [63:0]  ad_q[$], msg_q[$], exp_out[$];
  logic [127:0] exp_tag;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v};
    return d[n +: 64];
  endfunction

  function automatic logic [4:0][63:0] model_perm(input logic [4:0][63:0] s, input int nr);
    logic [4:0][63:0] t;
    logic [4:0] col, o;
    for (int r = 12 - nr; r < 12; r++) begin
      s[2][7:0] = s[2][7:0] ^ RC[r];
      for (int b = 0; b < 64; b++) begin
        col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        o = SBOX[col];
        t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
      end
      s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
      s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
      s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
      s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
      s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
    end
    return s;
  endfunction

  task automatic model_run(input bit dec, input bit ade, input logic [127:0] kk, input logic [127:0] nn);
    logic [4:0][63:0] s;
    logic [63:0] c;
    s[0] = 64'h80400c0600000000;
    s[1] = kk[127:64]; s[2] = kk[63:0]; s[3] = nn[127:64]; s[4] = nn[63:0];
    s = model_perm(s, 12);
    s[3] ^= kk[127:64]; s[4] ^= kk[63:0];
    if (ade) begin
      foreach (ad_q[i]) begin
        s[0] ^= ad_q[i];
        s = model_perm(s, 6);
      end
    end
    s[4][0] = ~s[4][0];
    exp_out.delete();
    foreach (msg_q[i]) begin
      c = s[0] ^ msg_q[i];
      exp_out.push_back(c);
      s[0] = dec ? msg_q[i] : c;
      if (i != msg_q.size() - 1) s = model_perm(s, 6);
    end
    s[1] ^= kk[127:64]; s[2] ^= kk[63:0];
    s = model_perm(s, 12);
    exp_tag = {s[3], s[4]} ^ kk;
  endtask

  // ---------------- drivers ----------------
  // stall_mode: 0 none, 1 ten cycles from first output, 2 random
  task automatic run_op(input int k, input bit dec, input bit ade, input logic [127:0] kk,
                        input logic [127:0] nn, input logic [127:0] ti, input int stall_mode,
                        input bit glitch, input string nm);
    logic [63:0] blk_d[$];
    bit          blk_l[$];
    logic [63:0] got[$];
    logic [63:0] held;
    logic [127:0] got_tag;
    logic got_ok;
    bit held_v, acc, done, stall;
    int idx, cyc, first_rdy, first_out, last_acc, tv_cyc, tv_cnt, u;
    u = unr_of(k);
    model_run(dec, ade, kk, nn);
    if (ade) foreach (ad_q[i]) begin blk_d.push_back(ad_q[i]); blk_l.push_back(i == ad_q.size() - 1); end
    foreach (msg_q[i]) begin blk_d.push_back(msg_q[i]); blk_l.push_back(i == msg_q.size() - 1); end
    idx = 0; cyc = 0; first_rdy = -1; first_out = -1; last_acc = -1; tv_cyc = -1; tv_cnt = 0;
    held_v = 0; done = 0; got_tag = '0; got_ok = 1'b0; held = '0;
    @(negedge clk);
    decrypt = dec; ad_en = ade; key = kk; nonce = nn; tag_in = ti;
    start_a[k] = 1'b1;
    @(negedge clk);
    start_a[k] = 1'b0;
    if (glitch) begin
      start_a[k] = 1'b1;
      decrypt = ~dec; ad_en = ~ade; key = ~kk; nonce = ~nn; tag_in = ~ti;
    end
    while (!done && cyc < 3000) begin
      if (cyc == 1) start_a[k] = 1'b0;
      case (stall_mode)
        1:       stall = (first_out >= 0) && (cyc < first_out + 10);
        2:       stall = ($urandom_range(0, 1) == 0);
        default: stall = 1'b0;
      endcase
      out_ready_a[k] = !stall;
      in_valid_a[k] = (idx < blk_d.size());
      in_data = (idx < blk_d.size()) ? blk_d[idx] : {$urandom, $urandom};
      in_last = (idx < blk_d.size()) ? blk_l[idx] : 1'b0;
      #1;
      if (first_rdy < 0 && in_ready_a[k]) first_rdy = cyc;
      if (first_out < 0 && out_valid_a[k]) first_out = cyc;
      if (held_v) check_eq({nm, "_out_hold"}, out_data_a[k], held);
      if (out_valid_a[k] && out_ready_a[k]) begin
        got.push_back(out_data_a[k]);
        held_v = 0;
      end else if (out_valid_a[k]) begin
        held = out_data_a[k];
        held_v = 1;
        check_eq({nm, "_stall_in_ready"}, in_ready_a[k], 1'b0);
      end
      if (tag_valid_a[k]) begin
        tv_cnt++;
        if (tv_cyc < 0) begin
          tv_cyc = cyc; got_tag = tag_a[k]; got_ok = tag_ok_a[k];
          check_eq({nm, "_busy_at_tag"}, busy_a[k], 1'b1);
        end
      end
      if (tv_cyc >= 0 && cyc == tv_cyc + 1) check_eq({nm, "_busy_fall"}, busy_a[k], 1'b0);
      acc = in_valid_a[k] && in_ready_a[k];
      @(posedge clk);
      if (acc) begin
        if (idx == blk_d.size() - 1) last_acc = cyc;
        idx++;
      end
      @(negedge clk);
      cyc++;
      done = (tv_cyc >= 0) && (cyc > tv_cyc + 1) && !out_valid_a[k];
    end
    in_valid_a[k] = 1'b0;
    out_ready_a[k] = 1'b1;
    check_eq({nm, "_completed"}, done, 1'b1);
    check_eq({nm, "_out_count"}, got.size(), exp_out.size());
    foreach (exp_out[i]) begin
      if (i < got.size()) check_eq($sformatf("%s_out%0d", nm, i), got[i], exp_out[i]);
    end
    check_eq({nm, "_tag"}, got_tag, exp_tag);
    check_eq({nm, "_tag_ok"}, got_ok, dec && (ti == exp_tag));
    check_eq({nm, "_tag_valid_cycles"}, tv_cnt, 1);
    check_eq({nm, "_init_len"}, first_rdy, 12 / u);
    check_eq({nm, "_final_len"}, tv_cyc - last_acc, 12 / u + 1);
  endtask

  // Abort an encryption while its permutation is running.
  task automatic reset_mid(input int k, input string nm);
    bit seen;
    seen = 0;
    @(negedge clk);
    decrypt = 1'b0; ad_en = 1'b0; key = {$urandom, $urandom, $urandom, $urandom};
    nonce = {$urandom, $urandom, $urandom, $urandom};
    start_a[k] = 1'b1;
    out_ready_a[k] = 1'b1;
    @(negedge clk);
    start_a[k] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (in_ready_a[k]) begin seen = 1; break; end
      @(negedge clk);
    end
    check_eq({nm, "_msg_ready"}, seen, 1'b1);
    in_valid_a[k] = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[k] = 1'b0;
    check_eq({nm, "_out_valid_pre"}, out_valid_a[k], 1'b1);
    check_eq({nm, "_busy_pre"}, busy_a[k], 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq({nm, "_busy"}, busy_a[k], 1'b0);
    check_eq({nm, "_out_valid"}, out_valid_a[k], 1'b0);
    check_eq({nm, "_in_ready"}, in_ready_a[k], 1'b0);
    check_eq({nm, "_tag_valid"}, tag_valid_a[k], 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] kk, nn, ct_tag;
    logic [63:0]  ct_q[$];
    int nad, nmsg;
    bit dec, ade;
    reset = 1'b1; start_a = '0; in_valid_a = '0; out_ready_a = '1;
    decrypt = 1'b0; ad_en = 1'b0; in_last = 1'b0; key = '0; nonce = '0; tag_in = '0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("rst%0d_busy", k), busy_a[k], 1'b0);
      check_eq($sformatf("rst%0d_in_ready", k), in_ready_a[k], 1'b0);
      check_eq($sformatf("rst%0d_out_valid", k), out_valid_a[k], 1'b0);
      check_eq($sformatf("rst%0d_tag_valid", k), tag_valid_a[k], 1'b0);
      check_eq($sformatf("rst%0d_tag_ok", k), tag_ok_a[k], 1'b0);
      check_eq($sformatf("rst%0d_out_data", k), out_data_a[k], 64'h0);
      check_eq($sformatf("rst%0d_tag", k), tag_a[k], 128'h0);
    end
    reset = 1'b0;

    for (int k = 0; k < NI; k++) begin
      // zero key/nonce, one AD block and one message block
      ad_q = '{64'h0}; msg_q = '{64'h0};
      run_op(k, 1'b0, 1'b1, '0, '0, '0, 0, 1'b0, $sformatf("u%0d_zero", unr_of(k)));

      // three message blocks without AD
      kk = {$urandom, $urandom, $urandom, $urandom};
      nn = {$urandom, $urandom, $urandom, $urandom};
      ad_q.delete();
      msg_q = '{64'h0123456789abcdef, 64'h1111111111111111, 64'h8000000000000000};
      run_op(k, 1'b0, 1'b0, kk, nn, '0, 0, 1'b0, $sformatf("u%0d_noad", unr_of(k)));
      ct_q = exp_out;
      ct_tag = exp_tag;

      // decrypt that ciphertext with the right tag, then with a flipped bit
      msg_q = ct_q;
      run_op(k, 1'b1, 1'b0, kk, nn, ct_tag, 0, 1'b0, $sformatf("u%0d_dec_ok", unr_of(k)));
      run_op(k, 1'b1, 1'b0, kk, nn, ct_tag ^ 128'h1, 0, 1'b0, $sformatf("u%0d_dec_bad", unr_of(k)));

      // output back-pressure for ten cycles
      ad_q = '{{$urandom, $urandom}, {$urandom, $urandom}};
      msg_q = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
      run_op(k, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, '0, 1, 1'b0, $sformatf("u%0d_stall", unr_of(k)));

      // abort mid-run, then a fresh run with a stray start while busy
      reset_mid(k, $sformatf("u%0d_rstmid", unr_of(k)));
      ad_q = '{{$urandom, $urandom}};
      msg_q = '{{$urandom, $urandom}, {$urandom, $urandom}};
      run_op(k, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, '0, 0, 1'b1, $sformatf("u%0d_after_rst", unr_of(k)));

      // random mixes with random back-pressure
      for (int r = 0; r < 3; r++) begin
        ade = 1'($urandom_range(0, 1));
        dec = 1'($urandom_range(0, 1));
        nad = $urandom_range(1, 3);
        nmsg = $urandom_range(1, 4);
        ad_q.delete(); msg_q.delete();
        for (int i = 0; i < nad; i++) ad_q.push_back({$urandom, $urandom});
        for (int i = 0; i < nmsg; i++) msg_q.push_back({$urandom, $urandom});
        run_op(k, dec, ade, {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               2, 1'b0, $sformatf("u%0d_rand%0d", unr_of(k), r));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
